// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data memory controller:
// access sizes, controller states, byte enables and load alignment/extension.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  // Size 3 is never legal; halves need even addresses, words need a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = 4'b0011 << off;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Synchronous 32-bit storage array with per-byte write enables and a registered read.
// No reset: contents are defined by the controller's clear sweep.
module mem_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store front end for the data memory: clear sweep after reset, alignment check,
// lane-replicated byte stores, extended loads and a 1- or 2-stage response pipeline.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 10,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DEPTH_LOG2+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy_init
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  ready_q;
  logic                  accept;
  logic                  req_err;

  logic [DEPTH_LOG2-1:0] bank_addr;
  logic [3:0]            bank_be;
  logic [31:0]           bank_wdata;
  logic [31:0]           bank_rdata;

  logic                  v1, wr1, err1, uns1;
  logic [1:0]            size1, off1;
  logic [31:0]           s1_rdata;
  logic                  s1_err;

  assign accept    = req_valid & ready_q;
  assign req_err   = misaligned(req_size, req_addr[1:0]);
  assign req_ready = ready_q;
  assign busy_init = (state == CLEAR);

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_IDX) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // ready is registered so it reads 0 during reset even when no sweep is configured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == RUN);
      if (state == CLEAR && clr_cnt != LAST_IDX) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    bank_addr  = req_addr[DEPTH_LOG2+1:2];
    bank_be    = 4'b0000;
    bank_wdata = req_wdata;
    if (state == CLEAR) begin
      bank_addr  = clr_cnt;
      bank_be    = 4'b1111;
      bank_wdata = '0;
    end else if (accept && req_write && !req_err) begin
      bank_be = byte_en(req_size, req_addr[1:0]);
      case (req_size)
        SIZE_B:  bank_wdata = {4{req_wdata[7:0]}};
        SIZE_H:  bank_wdata = {2{req_wdata[15:0]}};
        default: bank_wdata = req_wdata;
      endcase
    end
  end

  mem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
    .clk   (clk),
    .addr  (bank_addr),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      wr1   <= 1'b0;
      err1  <= 1'b0;
      uns1  <= 1'b0;
      size1 <= 2'd0;
      off1  <= 2'd0;
    end else begin
      v1    <= accept;
      wr1   <= req_write;
      err1  <= req_err;
      uns1  <= req_unsigned;
      size1 <= req_size;
      off1  <= req_addr[1:0];
    end
  end

  assign s1_rdata = (v1 && !wr1 && !err1) ? load_align(bank_rdata, size1, off1, uns1) : 32'd0;
  assign s1_err   = v1 & err1;

  if (READ_LATENCY == 1) begin : g_lat1
    assign rsp_valid = v1;
    assign rsp_rdata = s1_rdata;
    assign rsp_error = s1_err;
  end else begin : g_lat2
    logic        v2, err2;
    logic [31:0] rdata2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2     <= 1'b0;
        err2   <= 1'b0;
        rdata2 <= '0;
      end else begin
        v2     <= v1;
        err2   <= s1_err;
        rdata2 <= s1_rdata;
      end
    end
    assign rsp_valid = v2;
    assign rsp_rdata = rdata2;
    assign rsp_error = err2;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: latency-1 and latency-2 instances share stimulus and are
// checked every cycle against a byte-array memory model and timestamped response queues.
module tb_data_mem_ctrl;

  localparam int DL = 4;
  localparam int AW = DL + 2;
  localparam int NW = 1 << DL;
  localparam int NB = 4 * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;

  logic [1:0]    rdy, rv, re, busy;
  logic [31:0]   rd [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_LOG2(DL), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_error(re[0]), .busy_init(busy[0]));

  data_mem_ctrl #(.DEPTH_LOG2(DL), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_error(re[1]), .busy_init(busy[1]));

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t       q[2][$];
  logic [7:0] mem [NB];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         rst_m = 1'b1;
  int         rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Sweep of NW words starts on the first edge after reset release.
  function automatic bit model_ready();
    return !rst_m && (cyc - rel_cyc >= NW);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input int a);
    int unsigned v = 0;
    for (int i = 0; i < nbytes(sz); i++) v = v + (int'(mem[a + i]) << (8 * i));
    if (!u && sz == 2'd0 && v >= 128)   v = v + 32'hFFFFFF00;
    if (!u && sz == 2'd1 && v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic rsp_t model_accept(input logic w, input logic [1:0] sz, input logic u,
                                        input int a, input logic [31:0] wd);
    rsp_t r;
    r.err   = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    r.rdata = 32'd0;
    if (!r.err) begin
      if (w) begin
        for (int i = 0; i < nbytes(sz); i++) mem[a + i] = wd[8*i +: 8];
      end else begin
        r.rdata = model_load(sz, u, a);
      end
    end
    r.due = cyc + 1;
    q[0].push_back(r);
    r.due = cyc + 2;
    q[1].push_back(r);
    return r;
  endfunction

  always @(negedge clk) begin
    bit er;
    bit ev;
    er = model_ready();
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "ready_l1" : "ready_l2", {31'd0, rdy[k]}, {31'd0, er});
      chk(k == 0 ? "busy_l1" : "busy_l2", {31'd0, busy[k]}, {31'd0, rst_m || !er});
      ev = (q[k].size() > 0) && (q[k][0].due == cyc);
      chk(k == 0 ? "rsp_valid_l1" : "rsp_valid_l2", {31'd0, rv[k]}, {31'd0, ev});
      if (ev) begin
        chk(k == 0 ? "rdata_l1" : "rdata_l2", rd[k], q[k][0].rdata);
        chk(k == 0 ? "error_l1" : "error_l2", {31'd0, re[k]}, {31'd0, q[k][0].err});
        void'(q[k].pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!model_ready() && t < 4 * NW) begin
      step();
      t++;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input int a,
                       input logic [31:0] wd, output rsp_t r);
    wait_ready();
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = AW'(a);
    req_wdata    = wd;
    r = model_accept(w, sz, u, a, wd);
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst       = 1'b1;
    rst_m     = 1'b1;
    req_valid = 1'b0;
    q[0].delete();
    q[1].delete();
    repeat (hold) step();
    rst     = 1'b0;
    rst_m   = 1'b0;
    rel_cyc = cyc;
    for (int i = 0; i < NB; i++) mem[i] = 8'd0;
  endtask

  initial begin
    rsp_t r;
    step();
    do_reset(2);

    wait_ready();
    chk("pin_clear_load", model_load(2'd2, 1'b0, 'h3C), 32'h0000_0000);
    issue(1'b0, 2'd2, 1'b0, 'h3C, 32'd0, r);

    issue(1'b1, 2'd0, 1'b0, 'h05, 32'h0000_0080, r);
    issue(1'b1, 2'd2, 1'b0, 'h08, 32'h1122_3344, r);
    issue(1'b0, 2'd0, 1'b0, 'h05, 32'd0, r);
    chk("pin_sbyte", r.rdata, 32'hFFFF_FF80);
    issue(1'b0, 2'd0, 1'b1, 'h05, 32'd0, r);
    chk("pin_ubyte", r.rdata, 32'h0000_0080);
    issue(1'b0, 2'd1, 1'b0, 'h0A, 32'd0, r);
    chk("pin_shalf", r.rdata, 32'h0000_1122);

    issue(1'b1, 2'd2, 1'b0, 'h10, 32'hAABB_CCDD, r);
    issue(1'b1, 2'd1, 1'b0, 'h12, 32'h0000_5566, r);
    issue(1'b0, 2'd2, 1'b0, 'h10, 32'd0, r);
    chk("pin_lanes", r.rdata, 32'h5566_CCDD);

    issue(1'b0, 2'd2, 1'b0, 'h02, 32'd0, r);
    chk("pin_err_word", {31'd0, r.err}, 32'd1);
    issue(1'b1, 2'd1, 1'b0, 'h01, 32'hFFFF_FFFF, r);
    chk("pin_err_half", {31'd0, r.err}, 32'd1);
    issue(1'b0, 2'd3, 1'b0, 'h00, 32'd0, r);
    chk("pin_err_size", {31'd0, r.err}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 'h00, 32'd0, r);
    chk("pin_err_untouched", r.rdata, 32'h0000_0000);

    issue(1'b1, 2'd2, 1'b0, 'h20, 32'hDEAD_BEEF, r);
    issue(1'b0, 2'd2, 1'b0, 'h20, 32'd0, r);
    chk("pin_b2b", r.rdata, 32'hDEAD_BEEF);
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, NB - 1)), $urandom, r);
      end
    end
    idle(3);

    for (int w = 0; w < NW; w++) issue(1'b1, 2'd2, 1'b0, 4 * w, $urandom | 32'h1, r);
    issue(1'b0, 2'd2, 1'b0, 'h04, 32'd0, r);
    do_reset(2);
    repeat (NW / 2) step();
    do_reset(1);
    wait_ready();
    for (int w = 0; w < NW; w++) issue(1'b0, 2'd2, 1'b0, 4 * w, 32'd0, r);
    idle(4);
    chk("drain_l1", q[0].size(), 32'd0);
    chk("drain_l2", q[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
